// File: rtl/clock_mux_sel_ctrl_pkg.sv
// clock_mux_sel_ctrl_pkg: shared state encoding and settle-time limits for the clock_mux select sequencer
package clock_mux_sel_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        SWAP = 2'd2
    } state_t;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 255;
endpackage

// File: rtl/clock_sel_sync.sv
// clock_sel_sync: 2-flop synchronizer for the asynchronous mux select request
module clock_sel_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    // two-stage capture, both flops cleared by reset
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/clock_mux_sel_ctrl.sv
// clock_mux_sel_ctrl: glitch-free clock_mux select sequencer (gate off, wait, flip sel, wait, ungate, done)
// Optional: define CLOCK_MUX_SEL_CTRL_REQ_SYNC_EN to pass req_sel through clock_sel_sync first
module clock_mux_sel_ctrl
    import clock_mux_sel_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    localparam int CNT_W = $clog2(SETTLE_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic req_sel,
    output logic sel_out,
    output logic clk_en,
    output logic busy,
    output logic done
);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    if (SETTLE_CYC < SETTLE_MIN || SETTLE_CYC > SETTLE_MAX) begin : g_bad_settle
        $error("SETTLE_CYC out of range");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req_s;
    logic             req_q;

`ifdef CLOCK_MUX_SEL_CTRL_REQ_SYNC_EN
    clock_sel_sync u_sync (
        .clk(clk),
        .rst(rst),
        .d  (req_sel),
        .q  (req_s)
    );
`else
    assign req_s = req_sel;
`endif

    // sample the request so the IDLE compare only ever sees a registered value
    always_ff @(posedge clk) begin
        req_q <= rst ? 1'b0 : req_s;
    end

    // switch sequencer: sel_out only moves while the downstream gate is closed
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_out <= 1'b0;
            clk_en  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req_q != sel_out) begin
                    state  <= GATE;
                    clk_en <= 1'b0;
                    busy   <= 1'b1;
                    cnt    <= SETTLE_LD;
                end
                GATE: if (cnt != '0) cnt <= cnt - CNT_W'(1);
                else begin
                    sel_out <= ~sel_out;
                    state   <= SWAP;
                    cnt     <= SETTLE_LD;
                end
                SWAP: if (cnt != '0) cnt <= cnt - CNT_W'(1);
                else begin
                    clk_en <= 1'b1;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_mux_sel_ctrl.sv
// tb_clock_mux_sel_ctrl: self-checking bench for clock_mux_sel_ctrl (SETTLE_CYC=4 and SETTLE_CYC=1 instances)
`timescale 1ns/1ps
module tb_clock_mux_sel_ctrl;
`ifdef CLOCK_MUX_SEL_CTRL_REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int D = LAT - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_sel = 1'b0;
    logic [1:0] sel_out, clk_en, busy, done;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         e0 = 0;
    bit         chk_on = 1'b0;

    always #5 clk = ~clk;

    clock_mux_sel_ctrl #(.SETTLE_CYC(4)) u0 (
        .clk(clk), .rst(rst), .req_sel(req_sel),
        .sel_out(sel_out[0]), .clk_en(clk_en[0]), .busy(busy[0]), .done(done[0])
    );
    clock_mux_sel_ctrl #(.SETTLE_CYC(1)) u1 (
        .clk(clk), .rst(rst), .req_sel(req_sel),
        .sel_out(sel_out[1]), .clk_en(clk_en[1]), .busy(busy[1]), .done(done[1])
    );

    // model: a switch is an elapsed-time window of 2*S edges, sel flips at S, done at 2*S
    int   s_cyc [2] = '{4, 1};
    logic m_sel [2] = '{1'b0, 1'b0};
    logic m_busy[2] = '{1'b0, 1'b0};
    logic m_done[2] = '{1'b0, 1'b0};
    int   el    [2] = '{0, 0};
    logic hist  [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_sel[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; el[i] = 0;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    el[i]++;
                    if (el[i] == s_cyc[i]) m_sel[i] = !m_sel[i];
                    if (el[i] == 2 * s_cyc[i]) begin m_busy[i] = 1'b0; m_done[i] = 1'b1; end
                end else if (hist[LAT-1] != m_sel[i]) begin
                    m_busy[i] = 1'b1; el[i] = 0;
                end
            end
        end
        if (rst) hist = '{1'b0, 1'b0, 1'b0};
        else begin hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = req_sel; end
    end

    task automatic cmp(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, act, exp);
        end
    endtask

    // every-cycle compare of both instances against the model
    always @(negedge clk) if (chk_on) for (int i = 0; i < 2; i++) begin
        cmp($sformatf("u%0d.sel_out", i), sel_out[i], m_sel[i]);
        cmp($sformatf("u%0d.clk_en", i), clk_en[i], !m_busy[i]);
        cmp($sformatf("u%0d.busy", i), busy[i], m_busy[i]);
        cmp($sformatf("u%0d.done", i), done[i], m_done[i]);
    end

    // hand-computed expectation at edge E(k) (request-latency shift D applied)
    task automatic lit(input string nm, input int u, input int k,
                       input logic en, input logic sl, input logic bs, input logic dn);
        while (cyc < e0 + k + D) @(negedge clk);
        cmp({nm, ".clk_en"}, clk_en[u], en);
        cmp({nm, ".sel_out"}, sel_out[u], sl);
        cmp({nm, ".busy"}, busy[u], bs);
        cmp({nm, ".done"}, done[u], dn);
    endtask

    task automatic go(input logic v);
        @(negedge clk);
        req_sel = v;
        e0 = cyc + 1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_sva
        a_glitch: assert property (@(posedge clk) !$past(rst) && $changed(sel_out[g]) |-> !clk_en[g]);
        a_done:   assert property (@(posedge clk) disable iff (rst) done[g] |=> !done[g]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // reset held 3 cycles
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk_on = 1'b1;
            e0 = cyc - k - D;
            lit("rst", 0, k, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // single switch, plus the SETTLE_CYC=1 boundary on u1
        go(1'b1);
        lit("sw1_u1", 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("sw1", 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("s1_swap", 1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        lit("s1_done", 1, 3, 1'b1, 1'b1, 1'b0, 1'b1);
        lit("sw4", 0, 4, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("sw5", 0, 5, 1'b0, 1'b1, 1'b1, 1'b0);
        lit("sw8", 0, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        lit("sw9", 0, 9, 1'b1, 1'b1, 1'b0, 1'b1);
        lit("sw10", 0, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        // request changes while busy: one completed switch, then a switch back
        go(1'b0);
        while (cyc < e0 + 2) @(negedge clk);
        req_sel = 1'b1;
        lit("bz1", 0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        lit("bz5", 0, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("bz9", 0, 9, 1'b1, 1'b0, 1'b0, 1'b1);
        lit("bz10", 0, 10, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("bz14", 0, 14, 1'b0, 1'b1, 1'b1, 1'b0);
        lit("bz18", 0, 18, 1'b1, 1'b1, 1'b0, 1'b1);
        lit("bz19", 0, 19, 1'b1, 1'b1, 1'b0, 1'b0);
        // reset mid-switch while in SWAP
        @(negedge clk); rst = 1'b1; req_sel = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        go(1'b1);
        lit("mr6", 0, 6, 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        lit("mr7", 0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        req_sel = 1'b0;
        lit("mr8", 0, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        lit("mr9", 0, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        // request pulse shorter than a switch
        go(1'b1);
        @(negedge clk); req_sel = 1'b0;
        lit("tg9", 0, 9, 1'b1, 1'b1, 1'b0, 1'b1);
        lit("tg10", 0, 10, 1'b0, 1'b1, 1'b1, 1'b0);
        lit("tg18", 0, 18, 1'b1, 1'b0, 1'b0, 1'b1);
        lit("tg19", 0, 19, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
